float_result_stage: RTL

- Registered output stage placed directly downstream of the combinational float_divider, between it and the result consumer.
- Applies IEEE-style saturation to each result: overflow becomes signed infinity, underflow becomes signed zero.
- Buffers results through a 2-entry skid buffer with a valid/ready handshake.
- Keeps sticky exception flags and a saturating count of exceptional results for software/status readout.

---
 rtl/float_pkg.sv | 28 ++
 rtl/float_result_stage_if.sv | 30 +++
 rtl/float_saturate.sv | 39 +++
 rtl/float_result_stage.sv | 130 +++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared float types and helpers for the arithmetic result paths.
package float_pkg;

    localparam int unsigned FP_EXP_BITS = 8;
    localparam int unsigned FP_MAN_BITS = 23;
    localparam int unsigned FP_BITS     = 1 + FP_EXP_BITS + FP_MAN_BITS;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } float_flags_t;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b10
    } result_state_t;

    function automatic logic [FP_BITS-1:0] float_inf(input logic sign);
        return {sign, {FP_EXP_BITS{1'b1}}, {FP_MAN_BITS{1'b0}}};
    endfunction

    function automatic logic [FP_BITS-1:0] float_zero(input logic sign);
        return {sign, {FP_EXP_BITS{1'b0}}, {FP_MAN_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/float_result_stage_if.sv
// Handshake bundle between the divider, the result stage and the result consumer.
interface float_result_stage_if
    import float_pkg::*;
#(
    parameter int unsigned FLOAT_SIZE = FP_BITS
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [FLOAT_SIZE-1:0] in_data;
    logic                  in_overflow;
    logic                  in_underflow;
    logic                  in_inexact;
    logic                  out_valid;
    logic                  out_ready;
    logic [FLOAT_SIZE-1:0] out_data;
    float_flags_t          out_flags;

    // Environment side: divider producing beats and consumer draining them.
    modport master (
        output in_valid, in_data, in_overflow, in_underflow, in_inexact, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_overflow, in_underflow, in_inexact, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

endinterface

// File: rtl/float_saturate.sv
// Maps flagged results to IEEE specials: underflow -> signed zero, overflow -> signed infinity.
module float_saturate
    import float_pkg::*;
#(
    parameter int unsigned EXPONENT_SIZE = FP_EXP_BITS,
    parameter int unsigned MANTISSA_SIZE = FP_MAN_BITS,
    parameter int unsigned FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
    input  logic [FLOAT_SIZE-1:0] data_i,
    input  float_flags_t          flags_i,
    output logic [FLOAT_SIZE-1:0] data_o
);

    logic                  sign;
    logic [FLOAT_SIZE-1:0] inf_val;
    logic [FLOAT_SIZE-1:0] zero_val;

    assign sign = data_i[FLOAT_SIZE-1];

    if (EXPONENT_SIZE == FP_EXP_BITS && MANTISSA_SIZE == FP_MAN_BITS
        && FLOAT_SIZE == FP_BITS) begin : g_pkg_fmt
        assign inf_val  = float_inf(sign);
        assign zero_val = float_zero(sign);
    end else begin : g_other_fmt
        assign inf_val  = {sign, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
        assign zero_val = {sign, {EXPONENT_SIZE{1'b0}}, {MANTISSA_SIZE{1'b0}}};
    end

    // Underflow wins when the divider reports both.
    always_comb begin
        data_o = data_i;
        if (flags_i.underflow) begin
            data_o = zero_val;
        end else if (flags_i.overflow) begin
            data_o = inf_val;
        end
    end

endmodule

// File: rtl/float_result_stage.sv
// Registered divider output stage: saturation, 2-entry skid buffer, sticky flags and event count.
module float_result_stage
    import float_pkg::*;
#(
    parameter int unsigned FLOAT_SIZE    = FP_BITS,
    parameter int unsigned EXPONENT_SIZE = FP_EXP_BITS,
    parameter int unsigned MANTISSA_SIZE = FP_MAN_BITS,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    float_result_stage_if.slave    bus,
    input  logic                   flags_clear_i,
    output float_flags_t           sticky_flags_o,
    output logic [COUNT_WIDTH-1:0] exc_count_o
);

    result_state_t         state_q, state_d;
    logic [FLOAT_SIZE-1:0] main_data_q, main_data_d;
    logic [FLOAT_SIZE-1:0] skid_data_q, skid_data_d;
    float_flags_t          main_flags_q, main_flags_d;
    float_flags_t          skid_flags_q, skid_flags_d;
    float_flags_t          sticky_q, sticky_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    float_flags_t          raw_flags;
    logic [FLOAT_SIZE-1:0] sat_data;
    logic                  in_ready;
    logic                  out_valid;
    logic                  accept;
    logic                  deliver;

    assign raw_flags = '{overflow:  bus.in_overflow,
                         underflow: bus.in_underflow,
                         inexact:   bus.in_inexact};

    float_saturate #(
        .EXPONENT_SIZE (EXPONENT_SIZE),
        .MANTISSA_SIZE (MANTISSA_SIZE),
        .FLOAT_SIZE    (FLOAT_SIZE)
    ) u_saturate (
        .data_i  (bus.in_data),
        .flags_i (raw_flags),
        .data_o  (sat_data)
    );

    // Both handshake outputs decode only the state register, so out_ready never reaches in_ready.
    assign in_ready  = (state_q == StEmpty) || (state_q == StOne);
    assign out_valid = (state_q == StOne) || (state_q == StFull);
    assign accept    = bus.in_valid && in_ready;
    assign deliver   = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_data_q;
    assign bus.out_flags = main_flags_q;

    assign sticky_flags_o = sticky_q;
    assign exc_count_o    = count_q;

    always_comb begin
        state_d      = state_q;
        main_data_d  = main_data_q;
        main_flags_d = main_flags_q;
        skid_data_d  = skid_data_q;
        skid_flags_d = skid_flags_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_data_d  = sat_data;
                    main_flags_d = raw_flags;
                    state_d      = StOne;
                end
            end
            StOne: begin
                if (accept && deliver) begin
                    main_data_d  = sat_data;
                    main_flags_d = raw_flags;
                end else if (accept) begin
                    skid_data_d  = sat_data;
                    skid_flags_d = raw_flags;
                    state_d      = StFull;
                end else if (deliver) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (deliver) begin
                    main_data_d  = skid_data_q;
                    main_flags_d = skid_flags_q;
                    state_d      = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Clear is applied first so a coincident accept lands on a fresh slate.
    always_comb begin
        sticky_d = flags_clear_i ? '0 : sticky_q;
        count_d  = flags_clear_i ? '0 : count_q;
        if (accept) begin
            sticky_d = sticky_d | raw_flags;
            if ((raw_flags != '0) && (count_d != '1)) begin
                count_d = count_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StEmpty;
            main_data_q  <= '0;
            main_flags_q <= '0;
            skid_data_q  <= '0;
            skid_flags_q <= '0;
            sticky_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            main_data_q  <= main_data_d;
            main_flags_q <= main_flags_d;
            skid_data_q  <= skid_data_d;
            skid_flags_q <= skid_flags_d;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
        end
    end

endmodule
